// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, PC-select encodings, HALT opcode,
// bubble encoding and the fetch-stage state type.
package cpu_pkg;

    localparam int unsigned DEF_PC_W    = 9;
    localparam int unsigned DEF_INSTR_W = 16;

    // pc_sel encodings driven by control for the instruction in ID
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_BX  = 2'b10;
    localparam logic [1:0] PC_BL  = 2'b11;

    localparam logic [2:0]  OPC_HALT     = 3'b111;
    localparam logic [15:0] BUBBLE_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        StFetch,  // no request outstanding
        StWait,   // one request outstanding
        StHold,   // returned word parked in the skid while stalled
        StHalt    // HALT loaded, fetch stopped until reset
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register plus a one-entry skid buffer.
// Control priority: rst, bubble, hold, load_word, load_skid, otherwise bubble.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W    = DEF_PC_W,
    parameter int unsigned INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bubble,
    input  logic               hold,
    input  logic               load_word,
    input  logic               load_skid,
    input  logic               skid_push,
    input  logic [INSTR_W-1:0] word_instr,
    input  logic [PC_W-1:0]    word_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] skid_instr
);

    logic [PC_W-1:0] skid_pc;

    // IF/ID register update in priority order
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            valid <= 1'b0;
            instr <= INSTR_W'(BUBBLE_INSTR);
            pc    <= '0;
        end else if (hold) begin
            valid <= valid;
        end else if (load_word) begin
            valid <= 1'b1;
            instr <= word_instr;
            pc    <= word_pc;
        end else if (load_skid) begin
            valid <= 1'b1;
            instr <= skid_instr;
            pc    <= skid_pc;
        end else begin
            valid <= 1'b0;
            instr <= INSTR_W'(BUBBLE_INSTR);
            pc    <= '0;
        end
    end

    // Skid capture; occupancy is tracked by the fetch FSM (StHold)
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_instr <= '0;
            skid_pc    <= '0;
        end else if (skid_push) begin
            skid_instr <= word_instr;
            skid_pc    <= word_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and feeds
// the IF/ID register. Optional perf counters enabled by IF_PERF_CNT_EN.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W    = DEF_PC_W,
    parameter int unsigned INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic [1:0]         pc_sel,
    input  logic               id_cond_ok,
    input  logic [PC_W-1:0]    id_sximm,
    input  logic [15:0]        id_reg_target,
    input  logic               stall,
    input  logic               pc_load,
    input  logic               flush,
    output logic               if_id_valid,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               halted
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_bubbles
`endif
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    link_q;   // fetch address + 1 of the outstanding request
    logic               drop_q, drop_d;
    logic [INSTR_W-1:0] skid_instr;

    logic            take, redirect, rdata_halt, skid_halt;
    logic            word_arrive, word_take, skid_take, skid_push, halt_load, issue;
    logic [PC_W-1:0] target, pc_inc;
    logic            unused_target_hi;

    assign unused_target_hi = ^id_reg_target[15:PC_W];

    // Redirect, acceptance and issue decisions for this cycle
    always_comb begin
        take = (pc_sel == PC_BL) || (pc_sel == PC_BX) || ((pc_sel == PC_BR) && id_cond_ok);
        redirect = if_id_valid && !stall && take;
        target = (pc_sel == PC_BX) ? id_reg_target[PC_W-1:0] : if_id_pc + id_sximm;
        pc_inc = pc_q + PC_W'(1);

        rdata_halt  = imem_rdata[INSTR_W-1 -: 3] == OPC_HALT;
        skid_halt   = skid_instr[INSTR_W-1 -: 3] == OPC_HALT;
        word_arrive = (state_q == StWait) && imem_rvalid && !drop_q;
        word_take   = word_arrive && !stall && !redirect;
        skid_take   = (state_q == StHold) && !stall && !redirect;
        skid_push   = word_arrive && stall;
        // A flushed HALT never reaches IF/ID, so it does not stop fetch
        halt_load   = !flush && ((word_take && rdata_halt) || (skid_take && skid_halt));

        issue = pc_load && !redirect && !rst &&
                ((state_q == StFetch) ||
                 ((state_q == StWait) && imem_rvalid && !stall && (drop_q || !rdata_halt)));
    end

    // FSM next state, drop flag and PC next value
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        pc_d    = pc_q;
        unique case (state_q)
            StFetch: if (issue) state_d = StWait;
            StWait: begin
                if (imem_rvalid) begin
                    drop_d = 1'b0;
                    if (skid_push)      state_d = StHold;
                    else if (halt_load) state_d = StHalt;
                    else if (issue)     state_d = StWait;
                    else                state_d = StFetch;
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            StHold: begin
                if (redirect)       state_d = StFetch;
                else if (skid_take) state_d = halt_load ? StHalt : StFetch;
            end
            StHalt: state_d = StHalt;
        endcase
        if (redirect && state_q != StHalt) pc_d = target;
        else if (issue)                    pc_d = pc_inc;
    end

    // State, PC and link registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= '0;
            link_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            if (issue) link_q <= pc_inc;
        end
    end

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign halted    = (state_q == StHalt);

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .bubble     (flush || redirect),
        .hold       (stall),
        .load_word  (word_take),
        .load_skid  (skid_take),
        .skid_push  (skid_push),
        .word_instr (imem_rdata),
        .word_pc    (link_q),
        .valid      (if_id_valid),
        .instr      (if_id_instr),
        .pc         (if_id_pc),
        .skid_instr (skid_instr)
    );

`ifdef IF_PERF_CNT_EN
    logic fetched_inc, bubble_inc;
    assign fetched_inc = !flush && !stall && (word_take || skid_take);
    assign bubble_inc  = flush || (!stall && !(word_take || skid_take));

    // Saturating counts of valid and bubble IF/ID loads
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (fetched_inc && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
            if (bubble_inc && perf_bubbles != '1) perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the 5-stage CPU. It drives the instruction memory and owns the PC. It presents one 16-bit instruction per cycle to decode, where `control` and `HDU` consume it. It applies HDU stall, pc_load and flush, takes branch/BL/BX redirects from decode, and stops fetching permanently on HALT (opcode 111).

## Interface
- PC_W, 9, PC / instruction-memory address width (word addressed)
- INSTR_W, 16, instruction width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request this cycle
- imem_addr  out  PC_W  fetch address (= pc register)
- imem_rvalid  in  1  read data valid; at most one request outstanding, returned no earlier than next cycle
- imem_rdata  in  INSTR_W  instruction word
- pc_sel  in  2  from `control` for the instruction in ID: 00 seq, 01 B-type, 10 BX/BLX, 11 BL
- id_cond_ok  in  1  branch condition true (meaningful for pc_sel=01)
- id_sximm  in  PC_W  sign-extended branch offset, truncated to PC_W
- id_reg_target  in  16  register value for BX/BLX
- stall  in  1  HDU: hold IF/ID
- pc_load  in  1  HDU: PC may advance / new request may issue
- flush  in  1  HDU: replace IF/ID with bubble
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_instr  out  INSTR_W  instruction; 16'h0000 when bubble (opcode 000 decodes to no control activity)
- if_id_pc  out  PC_W  fetch address + 1 (link value / branch base)
- halted  out  1  HALT seen, fetch stopped

## Operation
- States: FETCH (no request outstanding), WAIT (one outstanding), HOLD (returned word parked in skid buffer because stall=1), HALT.
- redirect = if_id_valid & ~stall & (pc_sel==11 | pc_sel==10 | (pc_sel==01 & id_cond_ok)).
- Target: pc_sel 01/11 -> if_id_pc + id_sximm, mod 2^PC_W; pc_sel 10 -> id_reg_target[PC_W-1:0].
- Redirect: pc <= target. IF/ID <= bubble. Pending data is discarded: in WAIT, set drop flag and ignore the next rvalid; in HOLD, empty the skid and go to FETCH. Does not issue in the redirect cycle.
- Issue: imem_req = pc_load & ~redirect & ~rst & (state==FETCH | (state==WAIT & imem_rvalid & ~stall & word not HALT)). On issue, pc <= pc+1, mod 2^PC_W, so pc wraps from 2^PC_W-1 to 0.
- IF/ID write, in priority order:
  - rst -> bubble.
  - flush -> bubble, even when stall=1.
  - stall -> hold.
  - Accepted word (WAIT with rvalid & ~drop, or HOLD) -> valid, instr, pc.
  - Otherwise -> bubble.
- rvalid while stall=1 and not dropped: word goes to skid, state -> HOLD. No new request until stall drops.
- Word with instr[15:13]==111 loaded into IF/ID: state -> HALT and halted <= 1. No further requests. pc holds. Only rst exits HALT.
- Reset mid-request: state -> FETCH, drop cleared, a late rvalid after reset is ignored.

## Timing
- Reset values: pc 0, state FETCH, drop 0, skid empty, if_id_valid 0, if_id_instr 0, if_id_pc 0, halted 0. imem_req is 0 while rst=1.
- Latency: request in cycle n, rvalid in n+1, instruction on IF/ID outputs in n+2.
- Throughput: one instruction per cycle while rvalid returns next cycle and no stall.
- Redirect in cycle n: request to target in n+1, so a taken branch costs exactly one bubble.
- Redirect is ignored while stall=1; decode re-presents pc_sel once the stall clears.

## Configuration
- IF_PERF_CNT_EN defined: adds outputs perf_fetched[31:0] (valid IF/ID loads) and perf_bubbles[31:0] (bubble loads, including flush and redirect). Both are zeroed by rst and saturate at all-ones.
- IF_PERF_CNT_EN undefined: ports and counters absent. Functional behaviour is otherwise identical.

## Structure
- Shared package `cpu_pkg`:
  - PC_W and INSTR_W defaults
  - pc_sel encodings PC_SEQ/PC_BR/PC_BX/PC_BL
  - OPC_HALT = 3'b111
  - BUBBLE_INSTR = 16'h0000
  - fetch state enum
- One sub-module `if_id_reg`: the IF/ID register plus one-entry skid, with load/hold/bubble controls. The FSM and PC logic stay in fetch_stage.

## Test plan
- Reset, then memory returning 16'hD005, 16'hA0A1, 16'hA0A2 with one-cycle latency -> imem_addr 0,1,2 on consecutive cycles; if_id_pc 1,2,3; if_id_valid from cycle 2 after reset release.
- stall high for 3 cycles while a word returns -> word held in skid, no request issued, IF/ID unchanged. Word appears the cycle after stall falls, with no loss and no duplicate.
- B-type at address 5 with id_sximm=9'h1F8 (-8), id_cond_ok=1 -> next imem_addr 9'h1FE (wraparound), one bubble. Same case with id_cond_ok=0 -> sequential fetch, no bubble.
- BX with id_reg_target=16'h0123 issued while a request is outstanding -> returned word dropped, next address 9'h123.
- Word 16'hE000 fetched -> halted=1, imem_req stays 0 indefinitely; rst -> fetch resumes at address 0.
- flush and stall high in the same cycle -> IF/ID becomes bubble (instr 0, valid 0).
